// File: rtl/nco_mc_pkg.sv
// nco_mc_pkg: shared constants, types and helpers for the multi-channel NCO.
//   LAT            - enabled cycles from a channel's phase slot to its output sample
//   SEL_INC/OFF    - cfg_sel encodings
//   quad_e         - phase quadrant
//   ch_width()     - channel index width, never below 1
//   qrom_word()    - quarter-wave table entry, evaluated at elaboration
package nco_mc_pkg;

    localparam int unsigned LAT = 4;

    localparam logic SEL_INC = 1'b0;
    localparam logic SEL_OFF = 1'b1;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_e;

    function automatic int unsigned ch_width(input int unsigned nch);
        return (nch <= 2) ? 1 : $clog2(nch);
    endfunction

    // pi scaled by 2^60
    localparam logic [127:0] PI_Q60 = 128'h3243F6A8885A308D;

    // round((2^(mpr-1)-1) * sin(2*pi*(idx+0.5)/2^ppr)) in Q60 fixed point via a
    // Taylor series; the argument never exceeds pi/2 so all partial sums stay positive.
    function automatic logic [63:0] qrom_word(input int unsigned idx, input int unsigned ppr,
                                              input int unsigned mpr);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] sum;
        logic [127:0] amp;
        x    = (PI_Q60 * 128'(2 * idx + 1)) >> ppr;
        x2   = (x * x) >> 60;
        term = x;
        sum  = x;
        for (int k = 1; k <= 12; k++) begin
            term = ((term * x2) >> 60) / 128'((2 * k) * (2 * k + 1));
            if ((k % 2) == 1) begin
                sum = sum - term;
            end else begin
                sum = sum + term;
            end
        end
        amp = (128'd1 << (mpr - 1)) - 128'd1;
        return 64'(((sum * amp) + (128'd1 << 59)) >> 60);
    endfunction

endpackage

// File: rtl/nco_mc_qrom.sv
// nco_mc_qrom: quarter-wave sine ROM, 2^(PPR-2) words of MPR-1 bits, two synchronous
// read ports sharing one clock and one enable.
//   i_clk, i_rst        - clock, asynchronous active-high reset (clears read registers)
//   i_clken             - read enable; data registers hold while low
//   i_addr_a, i_addr_b  - read addresses
//   o_data_a, o_data_b  - registered read data
module nco_mc_qrom
    import nco_mc_pkg::*;
#(
    parameter int PPR = 12,
    parameter int MPR = 12
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clken,
    input  logic [PPR-3:0] i_addr_a,
    input  logic [PPR-3:0] i_addr_b,
    output logic [MPR-2:0] o_data_a,
    output logic [MPR-2:0] o_data_b
);

    localparam int DEPTH = 2 ** (PPR - 2);

    logic [MPR-2:0] w_rom [DEPTH];

    // Table contents are fixed at elaboration; they hold T[a] for a = 0..DEPTH-1.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        localparam logic [63:0] TV = qrom_word(gi, PPR, MPR);
        assign w_rom[gi] = TV[MPR-2:0];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_data_a <= '0;
            o_data_b <= '0;
        end else if (i_clken) begin
            o_data_a <= w_rom[i_addr_a];
            o_data_b <= w_rom[i_addr_b];
        end
    end

endmodule

// File: rtl/nco_mc.sv
// nco_mc: time-multiplexed multi-channel NCO producing tagged sine/cosine pairs.
//   clk, reset          - clock, asynchronous active-high reset
//   clken               - advance enable for slot counter, accumulators and pipeline
//   cfg_we/ch/sel/data  - per-channel increment (sel=0) or offset (sel=1) write
//   sync_i              - restart all accumulators and flush the pipeline (when clken)
//   fsin_o, fcos_o      - signed samples
//   ch_o, out_valid     - channel tag and valid of the current sample
module nco_mc
    import nco_mc_pkg::*;
#(
    parameter int    NCH  = 4,
    parameter int    APR  = 32,
    parameter int    PPR  = 12,
    parameter int    MPR  = 12,
    parameter string ROMF = "nco_mc_q.hex"
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clken,
    input  logic                        cfg_we,
    input  logic [ch_width(NCH)-1:0]    cfg_ch,
    input  logic                        cfg_sel,
    input  logic [APR-1:0]              cfg_data,
    input  logic                        sync_i,
    output logic signed [MPR-1:0]       fsin_o,
    output logic signed [MPR-1:0]       fcos_o,
    output logic [ch_width(NCH)-1:0]    ch_o,
    output logic                        out_valid
);

    localparam int CW = ch_width(NCH);

    // Channel banks are plain registers; only the sine table is a memory.
    logic [APR-1:0] r_acc [NCH];
    logic [APR-1:0] r_inc [NCH];
    logic [APR-1:0] r_off [NCH];
    logic [CW-1:0]  r_slot;

    logic [PPR-1:0] w_pt;
    logic [CW-1:0]  w_slot_nxt;

    // S1..S3 pipeline registers
    logic [PPR-1:0] r1_pt;
    logic [CW-1:0]  r1_ch;
    logic           r1_v;
    logic [PPR-3:0] r2_addr_a;
    logic [PPR-3:0] r2_addr_b;
    quad_e          r2_q;
    logic [CW-1:0]  r2_ch;
    logic           r2_v;
    quad_e          r3_q;
    logic [CW-1:0]  r3_ch;
    logic           r3_v;

    logic [MPR-2:0]        w_rom_a;
    logic [MPR-2:0]        w_rom_b;
    logic signed [MPR-1:0] w_ta;
    logic signed [MPR-1:0] w_tb;
    logic signed [MPR-1:0] w_sin;
    logic signed [MPR-1:0] w_cos;

    // Lookup phase uses the pre-update accumulator of the channel in slot.
    assign w_pt       = PPR'((r_acc[r_slot] + r_off[r_slot]) >> (APR - PPR));
    assign w_slot_nxt = (r_slot == CW'(NCH - 1)) ? '0 : r_slot + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_acc[i] <= '0;
            end
            r_slot <= '0;
        end else if (clken) begin
            if (sync_i) begin
                for (int i = 0; i < NCH; i++) begin
                    r_acc[i] <= '0;
                end
                r_slot <= '0;
            end else begin
                r_acc[r_slot] <= r_acc[r_slot] + r_inc[r_slot];
                r_slot        <= w_slot_nxt;
            end
        end
    end

    // Config writes ignore clken and sync; a write landing on a channel's own slot is
    // seen by that slot's next visit because S0 reads the registers before this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_inc[i] <= '0;
                r_off[i] <= '0;
            end
        end else if (cfg_we && (int'(cfg_ch) < NCH)) begin
            if (cfg_sel == SEL_OFF) begin
                r_off[cfg_ch] <= cfg_data;
            end else begin
                r_inc[cfg_ch] <= cfg_data;
            end
        end
    end

    // Sync clears every valid bit in flight, including the one about to reach the output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_pt     <= '0;
            r1_ch     <= '0;
            r1_v      <= 1'b0;
            r2_addr_a <= '0;
            r2_addr_b <= '0;
            r2_q      <= Q0;
            r2_ch     <= '0;
            r2_v      <= 1'b0;
            r3_q      <= Q0;
            r3_ch     <= '0;
            r3_v      <= 1'b0;
            fsin_o    <= '0;
            fcos_o    <= '0;
            ch_o      <= '0;
            out_valid <= 1'b0;
        end else if (clken) begin
            r1_pt     <= w_pt;
            r1_ch     <= r_slot;
            r1_v      <= ~sync_i;
            r2_addr_a <= r1_pt[PPR-3:0];
            r2_addr_b <= ~r1_pt[PPR-3:0];
            r2_q      <= quad_e'(r1_pt[PPR-1 -: 2]);
            r2_ch     <= r1_ch;
            r2_v      <= r1_v & ~sync_i;
            r3_q      <= r2_q;
            r3_ch     <= r2_ch;
            r3_v      <= r2_v & ~sync_i;
            fsin_o    <= w_sin;
            fcos_o    <= w_cos;
            ch_o      <= r3_ch;
            out_valid <= r3_v & ~sync_i;
        end
    end

    nco_mc_qrom #(
        .PPR (PPR),
        .MPR (MPR)
    ) u_qrom (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_clken  (clken),
        .i_addr_a (r2_addr_a),
        .i_addr_b (r2_addr_b),
        .o_data_a (w_rom_a),
        .o_data_b (w_rom_b)
    );

    // Table entries stay below full scale, so these negations cannot overflow.
    assign w_ta = {1'b0, w_rom_a};
    assign w_tb = {1'b0, w_rom_b};

    always_comb begin
        w_sin = '0;
        w_cos = '0;
        unique case (r3_q)
            Q0: begin
                w_sin = w_ta;
                w_cos = w_tb;
            end
            Q1: begin
                w_sin = w_tb;
                w_cos = -w_ta;
            end
            Q2: begin
                w_sin = -w_ta;
                w_cos = -w_tb;
            end
            Q3: begin
                w_sin = -w_tb;
                w_cos = w_ta;
            end
        endcase
    end

endmodule
